// File: rtl/fixed_dot_seq_if.sv
// Bus between the dot-product sequencer and its surroundings: the command
// inputs, the read ports of tensor RAMs A and B, the result-RAM write port,
// and the status flags. Signal suffixes are from the sequencer's point of view.
interface fixed_dot_seq_if #(
  parameter int addr_width = 3,
  parameter int data_width = 32
);
  logic                  start_i;
  logic [addr_width:0]   len_i;
  logic [addr_width-1:0] a_base_i;
  logic [addr_width-1:0] b_base_i;
  logic [addr_width-1:0] res_addr_i;
  logic [addr_width-1:0] a_addr_o;
  logic [addr_width-1:0] b_addr_o;
  logic [data_width-1:0] a_dout_i;
  logic [data_width-1:0] b_dout_i;
  logic                  out_we_o;
  logic [addr_width-1:0] out_addr_o;
  logic [data_width-1:0] out_din_o;
  logic                  busy_o;
  logic                  done_o;
  logic                  ovf_o;

  // Sequencer side.
  modport slave (
    input  start_i, len_i, a_base_i, b_base_i, res_addr_i, a_dout_i, b_dout_i,
    output a_addr_o, b_addr_o, out_we_o, out_addr_o, out_din_o, busy_o, done_o, ovf_o
  );

  // Controller / memory side.
  modport master (
    output start_i, len_i, a_base_i, b_base_i, res_addr_i, a_dout_i, b_dout_i,
    input  a_addr_o, b_addr_o, out_we_o, out_addr_o, out_din_o, busy_o, done_o, ovf_o
  );
endinterface

// File: rtl/fixed_dot_seq.sv
// Fixed-point (Q16.15) dot-product sequencer. Streams len element pairs out of
// RAMs A and B (1-cycle read latency), multiply-accumulates them in a 64-bit
// accumulator, and writes the saturated 32-bit result to the result RAM.
// Pipeline per element: address -> RAM data -> product register -> accumulator,
// with a valid bit travelling alongside each stage.
module fixed_dot_seq #(
  parameter int addr_width = 3,
  parameter int data_width = 32,
  parameter int frac_bits  = 15,
  parameter int relu       = 0
) (
  input logic            clk,
  input logic            rst,
  fixed_dot_seq_if.slave bus
);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, WRITE} state_t;

  state_t                state_q;
  logic [addr_width:0]   len_q;
  logic [addr_width:0]   cnt_q;
  logic [addr_width-1:0] res_addr_q;
  logic [addr_width-1:0] a_addr_q;
  logic [addr_width-1:0] b_addr_q;
  logic                  v_addr_q;
  logic                  v_data_q;
  logic                  v_prod_q;
  logic signed [63:0]    prod_q;
  logic signed [63:0]    acc_q;
  logic                  out_we_q;
  logic                  done_q;
  logic                  busy_q;
  logic                  ovf_q;
  logic [addr_width-1:0] out_addr_q;
  logic [data_width-1:0] out_din_q;

  logic                  accept_s;
  logic signed [63:0]    a_ext_s;
  logic signed [63:0]    b_ext_s;
  logic signed [63:0]    mul_s;
  logic signed [63:0]    prod_d;
  logic [32:0]           sat_s;
  logic [data_width-1:0] wr_din_d;
  logic                  wr_ovf_d;

  // Clamp a 64-bit signed value to the signed 32-bit range; bit 32 flags clamping.
  function automatic logic [32:0] sat32(input logic signed [63:0] v);
    if (v[63:31] == {33{v[63]}}) begin
      return {1'b0, v[31:0]};
    end else if (v[63]) begin
      return {1'b1, 32'h8000_0000};
    end else begin
      return {1'b1, 32'h7FFF_FFFF};
    end
  endfunction

  // A start is honoured only in IDLE and not on the cycle the previous done is
  // still showing, so a start coincident with busy falling waits one cycle.
  assign accept_s = (state_q == IDLE) && !done_q && bus.start_i;

  // Full-precision signed product rescaled back to Q.frac_bits (floor shift).
  always_comb begin
    a_ext_s = $signed({{32{bus.a_dout_i[31]}}, bus.a_dout_i});
    b_ext_s = $signed({{32{bus.b_dout_i[31]}}, bus.b_dout_i});
    mul_s   = a_ext_s * b_ext_s;
    prod_d  = mul_s >>> frac_bits;
  end

  // Result word: saturate the accumulator, then optionally clip negatives to 0.
  always_comb begin
    sat_s    = sat32(acc_q);
    wr_ovf_d = sat_s[32];
    if ((relu != 0) && sat_s[31]) begin
      wr_din_d = 32'h0000_0000;
    end else begin
      wr_din_d = sat_s[31:0];
    end
  end

  // Datapath pipeline: RAM data valid, product register, accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_data_q <= 1'b0;
      v_prod_q <= 1'b0;
      prod_q   <= 64'sd0;
      acc_q    <= 64'sd0;
    end else begin
      v_data_q <= v_addr_q;
      v_prod_q <= v_data_q;
      prod_q   <= prod_d;
      if (accept_s) begin
        acc_q <= 64'sd0;
      end else if (v_prod_q) begin
        acc_q <= acc_q + prod_q;
      end else begin
        acc_q <= acc_q;
      end
    end
  end

  // Control FSM: command latch, address generation, drain wait, result write.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      len_q      <= '0;
      cnt_q      <= '0;
      res_addr_q <= '0;
      a_addr_q   <= '0;
      b_addr_q   <= '0;
      v_addr_q   <= 1'b0;
      out_we_q   <= 1'b0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      ovf_q      <= 1'b0;
      out_addr_q <= '0;
      out_din_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          out_we_q <= 1'b0;
          done_q   <= 1'b0;
          v_addr_q <= 1'b0;
          busy_q   <= accept_s;
          if (accept_s) begin
            len_q      <= bus.len_i;
            res_addr_q <= bus.res_addr_i;
            ovf_q      <= 1'b0;
            if (bus.len_i == '0) begin
              state_q <= WRITE;
            end else begin
              a_addr_q <= bus.a_base_i;
              b_addr_q <= bus.b_base_i;
              cnt_q    <= (addr_width + 1)'(1);
              v_addr_q <= 1'b1;
              // A single element has nothing further to fetch.
              if (bus.len_i == (addr_width + 1)'(1)) begin
                state_q <= DRAIN;
              end else begin
                state_q <= FETCH;
              end
            end
          end
        end
        FETCH: begin
          a_addr_q <= a_addr_q + addr_width'(1);
          b_addr_q <= b_addr_q + addr_width'(1);
          cnt_q    <= cnt_q + (addr_width + 1)'(1);
          v_addr_q <= 1'b1;
          if (cnt_q + (addr_width + 1)'(1) == len_q) begin
            state_q <= DRAIN;
          end else begin
            state_q <= FETCH;
          end
        end
        DRAIN: begin
          v_addr_q <= 1'b0;
          // Last element is in the product stage: it lands in acc on this edge.
          if (!v_addr_q && !v_data_q && v_prod_q) begin
            state_q <= WRITE;
          end else begin
            state_q <= DRAIN;
          end
        end
        WRITE: begin
          out_we_q   <= 1'b1;
          done_q     <= 1'b1;
          out_addr_q <= res_addr_q;
          out_din_q  <= wr_din_d;
          ovf_q      <= wr_ovf_d;
          state_q    <= IDLE;
        end
        default: begin
          state_q  <= IDLE;
          v_addr_q <= 1'b0;
          out_we_q <= 1'b0;
          done_q   <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a_addr_o   = a_addr_q;
  assign bus.b_addr_o   = b_addr_q;
  assign bus.out_we_o   = out_we_q;
  assign bus.out_addr_o = out_addr_q;
  assign bus.out_din_o  = out_din_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.ovf_o      = ovf_q;

endmodule

// File: tb/tb_fixed_dot_seq.sv
// Directed bench for fixed_dot_seq (addr_width=3). Two instances run in
// lockstep on the same RAM contents: dut0 with relu=0 and dut1 with relu=1.
module tb_fixed_dot_seq;

  logic clk;
  logic rst;

  fixed_dot_seq_if #(.addr_width(3), .data_width(32)) bus0 ();
  fixed_dot_seq_if #(.addr_width(3), .data_width(32)) bus1 ();

  fixed_dot_seq #(.addr_width(3), .data_width(32), .frac_bits(15), .relu(0)) dut0 (
    .clk(clk), .rst(rst), .bus(bus0)
  );
  fixed_dot_seq #(.addr_width(3), .data_width(32), .frac_bits(15), .relu(1)) dut1 (
    .clk(clk), .rst(rst), .bus(bus1)
  );

  assign bus1.start_i    = bus0.start_i;
  assign bus1.len_i      = bus0.len_i;
  assign bus1.a_base_i   = bus0.a_base_i;
  assign bus1.b_base_i   = bus0.b_base_i;
  assign bus1.res_addr_i = bus0.res_addr_i;

  logic [31:0] ram_a [8];
  logic [31:0] ram_b [8];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM models with one-cycle registered read, one read port per instance.
  always @(posedge clk) begin
    bus0.a_dout_i <= ram_a[bus0.a_addr_o];
    bus0.b_dout_i <= ram_b[bus0.b_addr_o];
    bus1.a_dout_i <= ram_a[bus1.a_addr_o];
    bus1.b_dout_i <= ram_b[bus1.b_addr_o];
  end

  typedef struct packed {
    logic [7:0][31:0] a;
    logic [7:0][31:0] b;
    logic [3:0]       len;
    logic [2:0]       a_base;
    logic [2:0]       b_base;
    logic [2:0]       res;
    logic [31:0]      exp_din;
    logic             exp_ovf;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Load the RAMs, start one operation, and check addresses, latency and result.
  task automatic run_vec(input vec_t v, input int idx);
    int          cyc;
    int          lat;
    bit          seen;
    logic [2:0]  ea;
    logic [2:0]  eb;
    logic [31:0] relu_din;
    for (int k = 0; k < 8; k++) begin
      if (k < int'(v.len)) begin
        ram_a[3'(v.a_base + 3'(k))] = v.a[k];
        ram_b[3'(v.b_base + 3'(k))] = v.b[k];
      end
    end
    lat      = (v.len == 4'd0) ? 1 : int'(v.len) + 3;
    relu_din = v.exp_din[31] ? 32'h0 : v.exp_din;
    @(negedge clk);
    bus0.len_i      = v.len;
    bus0.a_base_i   = v.a_base;
    bus0.b_base_i   = v.b_base;
    bus0.res_addr_i = v.res;
    bus0.start_i    = 1'b1;
    @(posedge clk); #1;
    chk($sformatf("v%0d busy_after_start", idx), {63'd0, bus0.busy_o}, 64'd1);
    if (v.len != 4'd0) begin
      chk($sformatf("v%0d a_addr_c0", idx), {61'd0, bus0.a_addr_o}, {61'd0, v.a_base});
      chk($sformatf("v%0d b_addr_c0", idx), {61'd0, bus0.b_addr_o}, {61'd0, v.b_base});
    end
    @(negedge clk);
    bus0.start_i = 1'b0;
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (cyc < int'(v.len)) begin
        ea = v.a_base + 3'(cyc);
        eb = v.b_base + 3'(cyc);
        chk($sformatf("v%0d a_addr_c%0d", idx, cyc), {61'd0, bus0.a_addr_o}, {61'd0, ea});
        chk($sformatf("v%0d b_addr_c%0d", idx, cyc), {61'd0, bus0.b_addr_o}, {61'd0, eb});
      end
      if (bus0.out_we_o) seen = 1'b1;
    end
    chk($sformatf("v%0d latency", idx), 64'(seen ? cyc : -1), 64'(lat));
    chk($sformatf("v%0d out_din", idx), {32'd0, bus0.out_din_o}, {32'd0, v.exp_din});
    chk($sformatf("v%0d out_addr", idx), {61'd0, bus0.out_addr_o}, {61'd0, v.res});
    chk($sformatf("v%0d ovf", idx), {63'd0, bus0.ovf_o}, {63'd0, v.exp_ovf});
    chk($sformatf("v%0d done", idx), {63'd0, bus0.done_o}, 64'd1);
    chk($sformatf("v%0d relu_we", idx), {63'd0, bus1.out_we_o}, 64'd1);
    chk($sformatf("v%0d relu_din", idx), {32'd0, bus1.out_din_o}, {32'd0, relu_din});
    chk($sformatf("v%0d relu_ovf", idx), {63'd0, bus1.ovf_o}, {63'd0, v.exp_ovf});
    @(posedge clk); #1;
    chk($sformatf("v%0d busy_end", idx), {63'd0, bus0.busy_o}, 64'd0);
    chk($sformatf("v%0d we_end", idx), {62'd0, bus0.out_we_o, bus0.done_o}, 64'd0);
    chk($sformatf("v%0d din_hold", idx), {32'd0, bus0.out_din_o}, {32'd0, v.exp_din});
  endtask

  initial begin
    vec_t v;
    int   pulses;
    int   first_we;
    int   second_we;
    int   idle_gap;

    // Directed vectors, expected values worked out by hand in Q16.15.
    v = '0; v.len = 4'd3; v.res = 3'd5;                       // 1*1 + 2*1.5 + 0.5*-2 = 3.0
    v.a[0] = 32'h0000_8000; v.a[1] = 32'h0001_0000; v.a[2] = 32'h0000_4000;
    v.b[0] = 32'h0000_8000; v.b[1] = 32'h0000_C000; v.b[2] = 32'hFFFF_0000;
    v.exp_din = 32'h0001_8000; v.exp_ovf = 1'b0; vecs.push_back(v);
    v = '0; v.len = 4'd2; v.res = 3'd1;                       // positive saturation
    v.a[0] = 32'h7FFF_FFFF; v.a[1] = 32'h7FFF_FFFF;
    v.b[0] = 32'h7FFF_FFFF; v.b[1] = 32'h7FFF_FFFF;
    v.exp_din = 32'h7FFF_FFFF; v.exp_ovf = 1'b1; vecs.push_back(v);
    v = '0; v.len = 4'd1; v.res = 3'd2;                       // ovf clears on next run
    v.exp_din = 32'h0000_0000; v.exp_ovf = 1'b0; vecs.push_back(v);
    v = '0; v.len = 4'd1; v.res = 3'd4;                       // -2^-15 * 2^-15 floors to -1 lsb
    v.a[0] = 32'hFFFF_FFFF; v.b[0] = 32'h0000_0001;
    v.exp_din = 32'hFFFF_FFFF; v.exp_ovf = 1'b0; vecs.push_back(v);
    v = '0; v.len = 4'd2; v.res = 3'd6;                       // negative saturation
    v.a[0] = 32'h8000_0000; v.a[1] = 32'h8000_0000;
    v.b[0] = 32'h7FFF_FFFF; v.b[1] = 32'h7FFF_FFFF;
    v.exp_din = 32'h8000_0000; v.exp_ovf = 1'b1; vecs.push_back(v);
    v = '0; v.len = 4'd8; v.a_base = 3'd6; v.b_base = 3'd3; v.res = 3'd0;  // wrap, sum k^2 = 204
    for (int k = 0; k < 8; k++) begin
      v.a[k] = 32'(k + 1) << 15;
      v.b[k] = 32'(k + 1) << 15;
    end
    v.exp_din = 32'h0066_0000; v.exp_ovf = 1'b0; vecs.push_back(v);
    v = '0; v.len = 4'd0; v.res = 3'd7;                       // empty product
    v.exp_din = 32'h0000_0000; v.exp_ovf = 1'b0; vecs.push_back(v);
    v = '0; v.len = 4'd2; v.a_base = 3'd2; v.b_base = 3'd4; v.res = 3'd3;  // -1 lsb + 3.0
    v.a[0] = 32'h0000_4000; v.a[1] = 32'h0001_8000;
    v.b[0] = 32'hFFFF_FFFF; v.b[1] = 32'h0000_8000;
    v.exp_din = 32'h0001_7FFF; v.exp_ovf = 1'b0; vecs.push_back(v);

    for (int k = 0; k < 8; k++) begin
      ram_a[k] = 32'h0;
      ram_b[k] = 32'h0;
    end
    rst             = 1'b1;
    bus0.start_i    = 1'b0;
    bus0.len_i      = '0;
    bus0.a_base_i   = '0;
    bus0.b_base_i   = '0;
    bus0.res_addr_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", {63'd0, bus0.busy_o}, 64'd0);
    chk("reset_we_done_ovf", {61'd0, bus0.out_we_o, bus0.done_o, bus0.ovf_o}, 64'd0);
    chk("reset_addrs", {58'd0, bus0.a_addr_o, bus0.b_addr_o}, 64'd0);
    chk("reset_out", {29'd0, bus0.out_addr_o, bus0.out_din_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], i);
    end

    // Reset at E3 of a len=8 run aborts without a write.
    @(negedge clk);
    bus0.len_i = 4'd8; bus0.a_base_i = 3'd1; bus0.b_base_i = 3'd1; bus0.res_addr_i = 3'd2;
    bus0.start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus0.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("abort_busy", {63'd0, bus0.busy_o}, 64'd0);
    chk("abort_a_addr", {61'd0, bus0.a_addr_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int c = 0; c < 15; c++) begin
      @(posedge clk); #1;
      if (bus0.out_we_o) pulses++;
    end
    chk("abort_no_write", 64'(pulses), 64'd0);
    run_vec(vecs[0], 100);

    // Start pulsed at E2 of an active run is ignored.
    @(negedge clk);
    bus0.len_i = 4'd3; bus0.a_base_i = 3'd0; bus0.b_base_i = 3'd0; bus0.res_addr_i = 3'd5;
    bus0.start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus0.start_i = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus0.start_i = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus0.start_i = 1'b0;
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (bus0.out_we_o) pulses++;
    end
    chk("busy_start_pulses", 64'(pulses), 64'd1);
    chk("busy_start_din", {32'd0, bus0.out_din_o}, 64'h0001_8000);

    // Start held high: len=1 runs back to back with one idle cycle between.
    ram_a[0] = 32'h0001_0000; ram_b[0] = 32'h0001_0000;     // 2.0 * 2.0 = 4.0
    @(negedge clk);
    bus0.len_i = 4'd1; bus0.a_base_i = 3'd0; bus0.b_base_i = 3'd0; bus0.res_addr_i = 3'd3;
    bus0.start_i = 1'b1;
    @(posedge clk); #1;
    first_we  = -1;
    second_we = -1;
    idle_gap  = 0;
    for (int c = 1; c <= 16; c++) begin
      @(posedge clk); #1;
      if (bus0.out_we_o && first_we < 0) first_we = c;
      else if (bus0.out_we_o && second_we < 0) second_we = c;
      if (!bus0.busy_o && first_we >= 0 && second_we < 0) idle_gap++;
    end
    @(negedge clk);
    bus0.start_i = 1'b0;
    chk("hold_first_we", 64'(first_we), 64'd4);
    chk("hold_second_we", 64'(second_we), 64'd10);
    chk("hold_idle_gap", 64'(idle_gap), 64'd1);
    chk("hold_din", {32'd0, bus0.out_din_o}, 64'h0002_0000);
    repeat (10) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
